// File: rtl/if_stage_fetch_if.sv
// if_stage_fetch_if: control, redirect, loader and IF/ID signals of the fetch stage
interface if_stage_fetch_if #(
    parameter int NB_PC   = 32,
    parameter int NB_INST = 32,
    parameter int NB_BYTE = 8
);
    logic               i_IF_pipeline_enable;
    logic               i_IF_stall;
    logic               i_IF_flush;
    logic               i_IF_branch;
    logic [NB_PC-1:0]   i_IF_branch_addr;
    logic               i_IF_jr_jalr;
    logic [NB_PC-1:0]   i_IF_r31_data;
    logic               i_IF_jump;
    logic [NB_PC-1:0]   i_IF_jump_address;
    logic               i_IF_hlt;
    logic               i_IF_wr_en;
    logic [NB_BYTE-1:0] i_IF_wr_byte;
    logic [NB_INST-1:0] o_IF_inst;
    logic [NB_PC-1:0]   o_IF_pc;
    logic [NB_PC-1:0]   o_IF_pc_cur;
    logic               o_IF_halted;
    logic               o_IF_mem_full;

    modport slave (
        input  i_IF_pipeline_enable, i_IF_stall, i_IF_flush, i_IF_branch, i_IF_branch_addr,
               i_IF_jr_jalr, i_IF_r31_data, i_IF_jump, i_IF_jump_address, i_IF_hlt,
               i_IF_wr_en, i_IF_wr_byte,
        output o_IF_inst, o_IF_pc, o_IF_pc_cur, o_IF_halted, o_IF_mem_full
    );

    modport master (
        output i_IF_pipeline_enable, i_IF_stall, i_IF_flush, i_IF_branch, i_IF_branch_addr,
               i_IF_jr_jalr, i_IF_r31_data, i_IF_jump, i_IF_jump_address, i_IF_hlt,
               i_IF_wr_en, i_IF_wr_byte,
        input  o_IF_inst, o_IF_pc, o_IF_pc_cur, o_IF_halted, o_IF_mem_full
    );
endinterface

// File: rtl/if_stage_fetch.sv
// if_stage_fetch: PC, next-PC select, debug-loaded instruction memory and IF/ID register
module if_stage_fetch #(
    parameter int NB_PC       = 32,
    parameter int NB_INST     = 32,
    parameter int NB_BYTE     = 8,
    parameter int NB_MEM_ADDR = 8
) (
    input logic             i_clock,
    input logic             i_IF_reset,
    if_stage_fetch_if.slave bus
);
    localparam int NB_CNT = $clog2(NB_INST / NB_BYTE);
    localparam logic [NB_CNT-1:0] LAST = NB_CNT'(NB_INST / NB_BYTE - 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t                 state_q, state_d;
    logic [NB_PC-1:0]       pc_q, pc_d, npc_q, npc_d, pc_plus1, next_pc;
    logic [NB_INST-1:0]     inst_q, inst_d, asm_q, asm_d, mem_rd, word;
    logic [NB_CNT-1:0]      cnt_q, cnt_d;
    logic [NB_MEM_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic                   full_q, full_d, load, last, mem_we, hold, nop;
    logic [NB_INST-1:0]     mem [2**NB_MEM_ADDR];

    // Next-PC priority mux and asynchronous fetch; upper PC bits wrap the index
    always_comb begin
        pc_plus1 = pc_q + NB_PC'(1);
        next_pc  = bus.i_IF_branch  ? bus.i_IF_branch_addr :
                   bus.i_IF_jr_jalr ? bus.i_IF_r31_data :
                   bus.i_IF_jump    ? bus.i_IF_jump_address : pc_plus1;
        mem_rd   = mem[pc_q[NB_MEM_ADDR-1:0]];
    end

    // Next state: frozen while disabled (loader runs), NOP while halted, else redirect/flush/stall/advance
    always_comb begin
        hold     = bus.i_IF_stall && !bus.i_IF_branch;
        nop      = bus.i_IF_flush || (bus.i_IF_stall && bus.i_IF_branch);
        load     = !bus.i_IF_pipeline_enable && bus.i_IF_wr_en && !full_q;
        last     = cnt_q == LAST;
        word     = {asm_q[NB_INST-NB_BYTE-1:0], bus.i_IF_wr_byte};
        mem_we   = load && last;
        pc_d     = pc_q;
        inst_d   = inst_q;
        npc_d    = npc_q;
        state_d  = state_q;
        asm_d    = asm_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        if (bus.i_IF_pipeline_enable && state_q == HALTED) begin
            inst_d = '0;
            npc_d  = '0;
        end else if (bus.i_IF_pipeline_enable) begin
            pc_d    = hold ? pc_q : next_pc;
            inst_d  = nop ? '0 : hold ? inst_q : mem_rd;
            npc_d   = nop ? '0 : hold ? npc_q : pc_plus1;
            state_d = bus.i_IF_hlt ? HALTED : RUN;
        end else if (load) begin
            asm_d    = word;
            cnt_d    = last ? '0 : cnt_q + NB_CNT'(1);
            wr_ptr_d = last ? wr_ptr_q + NB_MEM_ADDR'(1) : wr_ptr_q;
            full_d   = last && &wr_ptr_q;
        end
    end

    // State registers; reset drops any partially assembled loader word
    always_ff @(posedge i_clock) begin
        if (i_IF_reset) begin
            pc_q     <= '0;
            inst_q   <= '0;
            npc_q    <= '0;
            state_q  <= RUN;
            asm_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            npc_q    <= npc_d;
            state_q  <= state_d;
            asm_q    <= asm_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
        end
    end

    // Program memory is deliberately not reset so a loaded program survives reset
    always_ff @(posedge i_clock) begin
        if (mem_we) mem[wr_ptr_q] <= word;
    end

    assign bus.o_IF_inst     = inst_q;
    assign bus.o_IF_pc       = npc_q;
    assign bus.o_IF_pc_cur   = pc_q;
    assign bus.o_IF_halted   = state_q == HALTED;
    assign bus.o_IF_mem_full = full_q;
endmodule
